// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - multi-precision add/subtract sequencer around a 64-bit Brent-Kung adder
//
// Modules:
//   sixty_four_bit_brentkung : 64-bit parallel-prefix adder.
//       i_a, i_b [63:0]  operands
//       i_cin            carry in
//       o_sum [63:0]     sum
//       o_cout           carry out of bit 63
//   multiword_add_sequencer  : streams operand word pairs (LSW first) through the adder,
//                              chaining the carry between words, one word per cycle.
//       clk, rst_n            clock, synchronous active-low reset
//       in_valid/in_ready     operand beat handshake
//       in_a, in_b [63:0]     operand words
//       in_sub                1 = A-B, 0 = A+B (sampled on the first beat)
//       in_first, in_last     least / most significant word markers
//       out_valid/out_ready   result beat handshake
//       out_sum [63:0]        result word
//       out_last              result word is the MSW
//       out_cout, out_ovf     carry out / signed overflow, only on the out_last beat
//       out_idx [CNT_W-1:0]   word index of out_sum
//       err                   sticky protocol error
//       out_zero              (only with MWADD_ZERO_FLAG_EN) whole result was zero, on out_last beat
// Configuration macro: MWADD_ZERO_FLAG_EN

module sixty_four_bit_brentkung (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_sum,
  output logic        o_cout
);

  // Brent-Kung prefix: up-sweep builds group (G,P) at power-of-two boundaries,
  // down-sweep fills in the remaining positions. cin is folded into bit 0's generate.
  function automatic logic [64:0] bk_add(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin);
    logic [63:0] p;
    logic [63:0] gg;
    logic [63:0] pp;
    logic [64:0] c;
    p     = a ^ b;
    gg    = a & b;
    pp    = p;
    gg[0] = gg[0] | (p[0] & cin);
    for (int d = 0; d < 6; d++) begin
      for (int i = (2 << d) - 1; i < 64; i += (2 << d)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    for (int d = 4; d >= 0; d--) begin
      for (int i = 3 * (1 << d) - 1; i < 64; i += (2 << d)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    c[0]    = cin;
    c[64:1] = gg;
    return {c[64], p ^ c[63:0]};
  endfunction

  logic [64:0] w_res;

  assign w_res  = bk_add(i_a, i_b, i_cin);
  assign o_sum  = w_res[63:0];
  assign o_cout = w_res[64];

endmodule

module multiword_add_sequencer #(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_sub,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_idx,
`ifdef MWADD_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(MAX_WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_carry;
  logic             r_sub;
  logic [CNT_W-1:0] r_idx;
  logic             r_out_valid;
  logic [63:0]      r_out_sum;
  logic             r_out_last;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_out_idx;
  logic             r_err;

  logic             w_xfer;
  logic             w_first_beat;
  logic             w_sub;
  logic [63:0]      w_b_eff;
  logic             w_cin;
  logic [CNT_W-1:0] w_idx;
  logic             w_force_last;
  logic             w_last;
  logic             w_proto_err;
  logic [63:0]      w_sum;
  logic             w_cout;
  logic             w_ovf;

  assign in_ready = !r_out_valid | out_ready;
  assign w_xfer   = in_valid & in_ready;

  // A beat starts a fresh operand when we are idle (even if first is missing)
  // or when first arrives mid-operand (restart, carry discarded).
  assign w_first_beat = (r_state == IDLE) | in_first;
  assign w_sub        = w_first_beat ? in_sub : r_sub;
  assign w_b_eff      = w_sub ? ~in_b : in_b;
  assign w_cin        = w_first_beat ? in_sub : r_carry;
  assign w_idx        = w_first_beat ? '0 : r_idx;
  assign w_force_last = !in_last && (w_idx == IDX_MAX);
  assign w_last       = in_last | w_force_last;
  assign w_proto_err  = ((r_state == IDLE) & !in_first) | ((r_state == BUSY) & in_first) |
                        w_force_last;

  sixty_four_bit_brentkung u_adder (
    .i_a    (in_a),
    .i_b    (w_b_eff),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry into bit 63 recovered from the sum bit; differs from cout on signed overflow.
  assign w_ovf = (w_sum[63] ^ in_a[63] ^ w_b_eff[63]) ^ w_cout;

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = w_last ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_carry     <= w_cout;
        r_sub       <= w_sub;
        r_idx       <= w_idx + IDX_ONE;
        r_out_valid <= 1'b1;
        r_out_sum   <= w_sum;
        r_out_last  <= w_last;
        r_out_cout  <= w_last & w_cout;
        r_out_ovf   <= w_last & w_ovf;
        r_out_idx   <= w_idx;
        if (w_proto_err) begin
          r_err <= 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_idx   = r_out_idx;
  assign err       = r_err;

`ifdef MWADD_ZERO_FLAG_EN
  logic r_nonzero;
  logic r_out_zero;
  logic w_nonzero;

  // Running OR of all result words of the operand; restarts with each first beat.
  assign w_nonzero = (w_first_beat ? 1'b0 : r_nonzero) | (|w_sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nonzero  <= 1'b0;
      r_out_zero <= 1'b0;
    end else if (w_xfer) begin
      r_nonzero  <= w_nonzero;
      r_out_zero <= w_last & !w_nonzero;
    end
  end

  assign out_zero = r_out_zero;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - directed self-checking bench for multiword_add_sequencer

module tb_multiword_add_sequencer;

  localparam int MAX_WORDS = 8;
  localparam int CNT_W     = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic             in_sub;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic             out_last;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] out_idx;
  logic             err;
`ifdef MWADD_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int checks = 0;
  int errors = 0;

  multiword_add_sequencer #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_idx   (out_idx),
`ifdef MWADD_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       input logic first, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_first = first;
    in_last  = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] sum, input logic last,
                          input logic cout, input logic ovf, input logic [CNT_W-1:0] idx);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sum"},   out_sum, sum);
    chk({tag, ".last"},  64'(out_last), 64'(last));
    chk({tag, ".cout"},  64'(out_cout), 64'(cout));
    chk({tag, ".ovf"},   64'(out_ovf), 64'(ovf));
    chk({tag, ".idx"},   64'(out_idx), 64'(idx));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.sum",   out_sum, 64'd0);
    chk("rst.idx",   64'(out_idx), 64'd0);
    chk("rst.err",   64'(err), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // 1-word add: all-ones + 1 wraps to zero with carry out
    drive(ONES, 64'd1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_beat("add1", 64'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    idle_in();
    tick();
    chk("add1.drain", 64'(out_valid), 64'd0);

    // 2-word add: carry crosses the word boundary
    drive(ONES, 64'd1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_beat("add2.w0", 64'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(64'd1, 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_beat("add2.w1", 64'd2, 1'b1, 1'b0, 1'b0, 4'd1);

    // 2-word sub 0 - 1: borrow everywhere, back-to-back with the previous operand
    drive(64'd0, 64'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_beat("sub2.w0", ONES, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_beat("sub2.w1", ONES, 1'b1, 1'b0, 1'b0, 4'd1);
    chk("sub2.err", 64'(err), 64'd0);

    // 4-word add with a 3-cycle output stall after word 1
    drive(ONES, 64'd1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_beat("bp.w0", 64'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(ONES, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_beat("bp.w1", 64'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    out_ready = 1'b0;
    drive(64'h1234, 64'd5, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp.in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_beat("bp.hold", 64'd0, 1'b0, 1'b0, 1'b0, 4'd1);
      chk("bp.hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk_beat("bp.w2", 64'h123A, 1'b0, 1'b0, 1'b0, 4'd2);
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_beat("bp.w3", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 4'd3);
    idle_in();
    tick();

    // first=1 during BUSY: error and restart at index 0 with sub relatched
    drive(64'd5, 64'd6, 1'b0, 1'b1, 1'b0);
    tick();
    chk_beat("restart.w0", 64'd11, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("restart.err0", 64'(err), 64'd0);
    drive(64'd2, 64'd3, 1'b1, 1'b1, 1'b1);
    tick();
    chk_beat("restart.new", ONES, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("restart.err1", 64'(err), 64'd1);
    idle_in();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2.err", 64'(err), 64'd0);

    // MAX_WORDS+1 beats without last: forced last at MAX_WORDS-1, then a fresh operand
    for (int i = 0; i < MAX_WORDS + 1; i++) begin
      drive(64'(i + 100), 64'd0, 1'b0, (i == 0), 1'b0);
      tick();
      if (i < MAX_WORDS - 1) begin
        chk_beat("long.w", 64'(i + 100), 1'b0, 1'b0, 1'b0, CNT_W'(i));
      end else if (i == MAX_WORDS - 1) begin
        chk_beat("long.forced", 64'(i + 100), 1'b1, 1'b0, 1'b0, CNT_W'(i));
      end else begin
        chk_beat("long.after", 64'(i + 100), 1'b0, 1'b0, 1'b0, 4'd0);
      end
      chk("long.err", 64'(err), 64'(i >= MAX_WORDS - 1));
    end

    // Reset mid-operand while a result is pending
    idle_in();
    out_ready = 1'b0;
    tick();
    chk("midrst.pending", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.err",   64'(err), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
    tick();
    chk_beat("midrst.add", 64'd12, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("midrst.err2", 64'(err), 64'd0);

`ifdef MWADD_ZERO_FLAG_EN
    drive(64'h55, 64'h55, 1'b1, 1'b1, 1'b0);
    tick();
    chk("zero.w0", 64'(out_zero), 64'd0);
    drive(64'h9, 64'h9, 1'b1, 1'b0, 1'b1);
    tick();
    chk("zero.w1", 64'(out_zero), 64'd1);
    chk("zero.cout", 64'(out_cout), 64'd1);
`endif

    idle_in();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
